// File: rtl/sdreq_mem_ctrl.sv
// ============================================================================
// Module   : sdreq_mem_ctrl
// Purpose  : Memory-side target for the sdreq/sursp channel pair. Accepts one
//            block request at a time, performs a fixed-latency read/write on a
//            backing block store and tracks one sharer bit per block to pick
//            exclusive or shared fill responses.
// Option   : SDREQ_MEM_ERR_CHK_EN - answer illegal opcodes and out-of-range
//            addresses with ERR and count them in err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdreq_mem_ctrl #(
    parameter int PADDR_WIDTH = 64,
    parameter int BLK_WIDTH   = 512,
    parameter int SADDR_WIDTH = PADDR_WIDTH - $clog2(BLK_WIDTH / 8),
    parameter int MEM_BLK     = 4096,
    parameter int MEM_LAT     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   sdreq_valid,
    input  logic [2:0]             sdreq_op,
    input  logic [SADDR_WIDTH-1:0] sdreq_addr,
    input  logic [BLK_WIDTH-1:0]   sdreq_data,
    output logic                   sdreq_ready,
    output logic                   sursp_valid,
    output logic [2:0]             sursp_rsp,
    output logic [BLK_WIDTH-1:0]   sursp_data,
    input  logic                   sursp_ready,
    output logic [7:0]             err_cnt
);

    localparam int IDX_W = $clog2(MEM_BLK);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [2:0] C_OP_GETS = 3'b000;
    localparam logic [2:0] C_OP_GETX = 3'b001;
    localparam logic [2:0] C_OP_UPGR = 3'b010;
    localparam logic [2:0] C_OP_WB   = 3'b011;

    localparam logic [2:0] C_RSP_OKAY   = 3'b000;
    localparam logic [2:0] C_RSP_DATA_E = 3'b001;
    localparam logic [2:0] C_RSP_DATA_S = 3'b010;
    localparam logic [2:0] C_RSP_ERR    = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RSP    = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic                   w_accept;
    logic                   w_done;
    logic                   w_err;
    logic [CNT_W-1:0]       r_cnt;
    logic [2:0]             r_op;
    logic [SADDR_WIDTH-1:0] r_addr;
    logic [BLK_WIDTH-1:0]   r_data;
    logic [IDX_W-1:0]       w_idx;
    logic [BLK_WIDTH-1:0]   w_rd_data;

    // Backing store. r_vld marks blocks written since reset so that reset can
    // clear the whole store in one cycle: an unwritten block reads as zero.
    logic [BLK_WIDTH-1:0]   r_mem [MEM_BLK];
    logic [MEM_BLK-1:0]     r_vld;
    logic [MEM_BLK-1:0]     r_shr;

    assign w_idx       = r_addr[IDX_W-1:0];
    assign w_rd_data   = r_vld[w_idx] ? r_mem[w_idx] : '0;
    assign sdreq_ready = (r_state == S_IDLE) && !rst;
    assign sursp_valid = (r_state == S_RSP);

`ifdef SDREQ_MEM_ERR_CHK_EN
    logic [7:0] r_err_cnt;

    assign w_err   = r_op[2] || ((r_addr >> IDX_W) != '0);
    assign err_cnt = r_err_cnt;

    // Saturating error counter, bumped when an ERR response is produced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_cnt <= 8'd0;
        end else if (w_done && w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end
`else
    // Address high part aliases onto the index and is deliberately dropped.
    logic w_unused_hi;

    assign w_unused_hi = ^(r_addr >> IDX_W);
    assign w_err       = 1'b0;
    assign err_cnt     = 8'd0;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state and strobes: accept in IDLE, finish when the counter expires.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sdreq_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == '0) begin
                    w_done      = 1'b1;
                    w_state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (sursp_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Request buffer, latency counter, sharer/valid bits and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt      <= '0;
            r_op       <= 3'b000;
            r_addr     <= '0;
            r_data     <= '0;
            r_vld      <= '0;
            r_shr      <= '0;
            sursp_rsp  <= C_RSP_OKAY;
            sursp_data <= '0;
        end else if (w_accept) begin
            r_cnt  <= C_CNT_LOAD;
            r_op   <= sdreq_op;
            r_addr <= sdreq_addr;
            r_data <= sdreq_data;
        end else if (w_done) begin
            if (w_err) begin
                sursp_rsp  <= C_RSP_ERR;
                sursp_data <= '0;
            end else begin
                case (r_op)
                    C_OP_GETS: begin
                        sursp_data   <= w_rd_data;
                        sursp_rsp    <= r_shr[w_idx] ? C_RSP_DATA_S : C_RSP_DATA_E;
                        r_shr[w_idx] <= 1'b1;
                    end
                    C_OP_GETX: begin
                        sursp_data   <= w_rd_data;
                        sursp_rsp    <= C_RSP_DATA_E;
                        r_shr[w_idx] <= 1'b1;
                    end
                    C_OP_UPGR: begin
                        sursp_data   <= '0;
                        sursp_rsp    <= C_RSP_OKAY;
                        r_shr[w_idx] <= 1'b1;
                    end
                    C_OP_WB: begin
                        sursp_data   <= '0;
                        sursp_rsp    <= C_RSP_OKAY;
                        r_shr[w_idx] <= 1'b0;
                        r_vld[w_idx] <= 1'b1;
                    end
                    default: begin
                        sursp_data <= '0;
                        sursp_rsp  <= C_RSP_OKAY;
                    end
                endcase
            end
        end else if (r_state == S_ACCESS) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Store array write; a WB commits only on its ACCESS->RSP edge.
    always_ff @(posedge clk) begin
        if (w_done && !w_err && (r_op == C_OP_WB)) begin
            r_mem[w_idx] <= r_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdreq_mem_ctrl.sv
// ============================================================================
// Module   : tb_sdreq_mem_ctrl
// Purpose  : Directed, table-driven bench for sdreq_mem_ctrl (MEM_LAT=4 main
//            instance plus a MEM_LAT=1 instance for minimum latency).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdreq_mem_ctrl;

    localparam int LAT  = 4;
    localparam int SAW  = 64 - 6;
    localparam int M1SAW = 64 - 2;

    localparam logic [2:0] GETS = 3'b000, GETX = 3'b001, UPGR = 3'b010, WB = 3'b011;
    localparam logic [2:0] OKAY = 3'b000, DATA_E = 3'b001, DATA_S = 3'b010, ERR = 3'b111;
    localparam logic [511:0] PAT_A5 = {64{8'hA5}};
    localparam logic [511:0] PAT_5A = {64{8'h5A}};

`ifdef SDREQ_MEM_ERR_CHK_EN
    localparam logic [2:0]   EXP_ILL_RSP = ERR;
    localparam logic [2:0]   EXP_HI_RSP  = ERR;
    localparam logic [511:0] EXP_HI_DATA = '0;
    localparam logic [7:0]   CNT1 = 8'd1;
    localparam logic [7:0]   CNT2 = 8'd2;
`else
    localparam logic [2:0]   EXP_ILL_RSP = OKAY;
    localparam logic [2:0]   EXP_HI_RSP  = DATA_S;
    localparam logic [511:0] EXP_HI_DATA = PAT_5A;
    localparam logic [7:0]   CNT1 = 8'd0;
    localparam logic [7:0]   CNT2 = 8'd0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             sdreq_valid;
    logic [2:0]       sdreq_op;
    logic [SAW-1:0]   sdreq_addr;
    logic [511:0]     sdreq_data;
    logic             sdreq_ready;
    logic             sursp_valid;
    logic [2:0]       sursp_rsp;
    logic [511:0]     sursp_data;
    logic             sursp_ready;
    logic [7:0]       err_cnt;

    logic             m1_sdreq_valid;
    logic [2:0]       m1_sdreq_op;
    logic [M1SAW-1:0] m1_sdreq_addr;
    logic [31:0]      m1_sdreq_data;
    logic             m1_sdreq_ready;
    logic             m1_sursp_valid;
    logic [2:0]       m1_sursp_rsp;
    logic [31:0]      m1_sursp_data;
    logic             m1_sursp_ready;
    logic [7:0]       m1_err_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdreq_mem_ctrl #(
        .PADDR_WIDTH(64), .BLK_WIDTH(512), .MEM_BLK(4096), .MEM_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .sdreq_valid(sdreq_valid), .sdreq_op(sdreq_op), .sdreq_addr(sdreq_addr),
        .sdreq_data(sdreq_data), .sdreq_ready(sdreq_ready),
        .sursp_valid(sursp_valid), .sursp_rsp(sursp_rsp), .sursp_data(sursp_data),
        .sursp_ready(sursp_ready), .err_cnt(err_cnt)
    );

    sdreq_mem_ctrl #(
        .PADDR_WIDTH(64), .BLK_WIDTH(32), .MEM_BLK(64), .MEM_LAT(1)
    ) dut_m1 (
        .clk(clk), .rst(rst),
        .sdreq_valid(m1_sdreq_valid), .sdreq_op(m1_sdreq_op), .sdreq_addr(m1_sdreq_addr),
        .sdreq_data(m1_sdreq_data), .sdreq_ready(m1_sdreq_ready),
        .sursp_valid(m1_sursp_valid), .sursp_rsp(m1_sursp_rsp), .sursp_data(m1_sursp_data),
        .sursp_ready(m1_sursp_ready), .err_cnt(m1_err_cnt)
    );

    typedef struct {
        logic [2:0]     op;
        logic [SAW-1:0] addr;
        logic [511:0]   data;
        logic [2:0]     rsp;
        logic [511:0]   edata;
        logic [7:0]     ecnt;
    } vec_t;

    vec_t vt [13];

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    // Issue one request, check latency/response, optionally stall the response.
    task automatic do_req(input logic [2:0] op, input logic [SAW-1:0] addr,
                          input logic [511:0] data, input logic [2:0] ersp,
                          input logic [511:0] edata, input logic [7:0] ecnt,
                          input int hold, input string nm);
        int n;
        logic ok;
        n = 0;
        while (!sdreq_ready && n < 100) begin
            @(posedge clk); #1; n++;
        end
        sdreq_valid = 1'b1;
        sdreq_op    = op;
        sdreq_addr  = addr;
        sdreq_data  = data;
        @(posedge clk); #1;
        sdreq_valid = 1'b0;
        n = 0;
        while (!sursp_valid && n < 100) begin
            @(posedge clk); #1; n++;
        end
        chk({nm, " latency"}, 512'(n), 512'(LAT));
        chk({nm, " rsp"}, 512'(sursp_rsp), 512'(ersp));
        chk({nm, " data"}, sursp_data, edata);
        chk({nm, " err_cnt"}, 512'(err_cnt), 512'(ecnt));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            ok = sursp_valid && (sursp_rsp == ersp) && (sursp_data == edata) && !sdreq_ready;
            chk({nm, " held"}, 512'(ok), 512'(1));
        end
        sursp_ready = 1'b1;
        @(posedge clk); #1;
        sursp_ready = 1'b0;
        chk({nm, " valid drop"}, 512'(sursp_valid), 512'(0));
        chk({nm, " ready back"}, 512'(sdreq_ready), 512'(1));
    endtask

    initial begin
        vt[0]  = '{GETS, 58'h10,   '0,     DATA_E,      '0,          8'd0};
        vt[1]  = '{GETS, 58'h10,   '0,     DATA_S,      '0,          8'd0};
        vt[2]  = '{WB,   58'h20,   PAT_A5, OKAY,        '0,          8'd0};
        vt[3]  = '{GETX, 58'h20,   '0,     DATA_E,      PAT_A5,      8'd0};
        vt[4]  = '{GETS, 58'h20,   '0,     DATA_S,      PAT_A5,      8'd0};
        vt[5]  = '{UPGR, 58'h40,   '0,     OKAY,        '0,          8'd0};
        vt[6]  = '{GETS, 58'h40,   '0,     DATA_S,      '0,          8'd0};
        vt[7]  = '{WB,   58'h10,   PAT_5A, OKAY,        '0,          8'd0};
        vt[8]  = '{GETS, 58'h10,   '0,     DATA_E,      PAT_5A,      8'd0};
        vt[9]  = '{3'b101, 58'h50, PAT_A5, EXP_ILL_RSP, '0,          CNT1};
        vt[10] = '{GETS, 58'h1010, '0,     EXP_HI_RSP,  EXP_HI_DATA, CNT2};
        vt[11] = '{GETS, 58'h50,   '0,     DATA_E,      '0,          CNT2};
        vt[12] = '{GETX, 58'h40,   '0,     DATA_E,      '0,          CNT2};

        rst            = 1'b1;
        sdreq_valid    = 1'b0;
        sdreq_op       = 3'b000;
        sdreq_addr     = '0;
        sdreq_data     = '0;
        sursp_ready    = 1'b0;
        m1_sdreq_valid = 1'b0;
        m1_sdreq_op    = 3'b000;
        m1_sdreq_addr  = '0;
        m1_sdreq_data  = '0;
        m1_sursp_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst sdreq_ready", 512'(sdreq_ready), 512'(0));
        chk("rst sursp_valid", 512'(sursp_valid), 512'(0));
        chk("rst sursp_rsp", 512'(sursp_rsp), 512'(0));
        chk("rst sursp_data", sursp_data, '0);
        chk("rst err_cnt", 512'(err_cnt), 512'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("post-rst ready", 512'(sdreq_ready), 512'(1));
        chk("m1 idle valid", 512'(m1_sursp_valid), 512'(0));

        // Table-driven main function
        for (int i = 0; i < 13; i++) begin
            do_req(vt[i].op, vt[i].addr, vt[i].data, vt[i].rsp, vt[i].edata,
                   vt[i].ecnt, 0, $sformatf("vec%0d", i));
        end

        // Response stalled for 10 cycles
        do_req(GETS, 58'h20, '0, DATA_S, PAT_A5, CNT2, 10, "hold");

        // Reset during ACCESS of a writeback
        begin
            int n;
            n = 0;
            while (!sdreq_ready && n < 100) begin
                @(posedge clk); #1; n++;
            end
            sdreq_valid = 1'b1;
            sdreq_op    = WB;
            sdreq_addr  = 58'h30;
            sdreq_data  = 512'hFF;
            @(posedge clk); #1;
            sdreq_valid = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            chk("abort sdreq_ready", 512'(sdreq_ready), 512'(0));
            chk("abort sursp_valid", 512'(sursp_valid), 512'(0));
            chk("abort sursp_rsp", 512'(sursp_rsp), 512'(0));
            chk("abort sursp_data", sursp_data, '0);
            chk("abort err_cnt", 512'(err_cnt), 512'(0));
            repeat (2) @(posedge clk);
            #1;
            rst = 1'b0;
        end
        do_req(GETS, 58'h30, '0, DATA_E, '0, 8'd0, 0, "after-abort 0x30");
        do_req(GETS, 58'h20, '0, DATA_E, '0, 8'd0, 0, "after-abort 0x20");

        // MEM_LAT=1 instance, sursp_ready held high throughout
        begin
            int n;
            n = 0;
            while (!m1_sdreq_ready && n < 100) begin
                @(posedge clk); #1; n++;
            end
            m1_sdreq_valid = 1'b1;
            m1_sdreq_op    = GETS;
            m1_sdreq_addr  = 62'h5;
            @(posedge clk); #1;
            m1_sdreq_valid = 1'b0;
            chk("m1 E0 valid", 512'(m1_sursp_valid), 512'(0));
            chk("m1 E0 ready", 512'(m1_sdreq_ready), 512'(0));
            @(posedge clk); #1;
            chk("m1 E1 valid", 512'(m1_sursp_valid), 512'(1));
            chk("m1 E1 rsp", 512'(m1_sursp_rsp), 512'(DATA_E));
            chk("m1 E1 data", 512'(m1_sursp_data), 512'(0));
            @(posedge clk); #1;
            chk("m1 E2 valid", 512'(m1_sursp_valid), 512'(0));
            chk("m1 E2 ready", 512'(m1_sdreq_ready), 512'(1));
            chk("m1 err_cnt", 512'(m1_err_cnt), 512'(0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
